mul_div_unit: RTL and testbench

Parametrised iterative multiply/divide unit with architectural HI/LO registers, sitting in the EX stage beside the combinational ALU. It executes signed and unsigned multiply and divide over many cycles while the pipeline stalls on `busy`, and handles single-cycle moves into HI/LO. Results are read combinationally from `Hi`/`Lo` for MFHI/MFLO forwarding.

---
 rtl/mul_div_unit.sv | 197 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide run on magnitudes, one bit per
// cycle, and a final FIX cycle applies the recorded signs and writes HI/LO.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned AW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   opa_q, opa_d;    // multiplicand or divisor magnitude
  logic [AW-1:0]  acc_q, acc_d;    // product, or {remainder, quotient/dividend}
  logic           neg_q, neg_d;    // product or quotient sign
  logic           rneg_q, rneg_d;  // remainder sign
  logic           div_q, div_d;
  logic           dz_q, dz_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           sgn_op;
  logic [W-1:0]   mag1, mag2;
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic           div_ge;
  logic [W-1:0]   div_diff;
  logic [AW-1:0]  prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;

  assign busy = busy_q;
  assign done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

  // Operand magnitudes and one-step datapath results
  always_comb begin
    sgn_op    = ~op[0];
    mag1      = (sgn_op && In1[W-1]) ? (~In1 + W'(1)) : In1;
    mag2      = (sgn_op && In2[W-1]) ? (~In2 + W'(1)) : In2;
    mul_sum   = {1'b0, acc_q[AW-1:W]} + (acc_q[0] ? {1'b0, opa_q} : (W+1)'(0));
    div_shift = {acc_q[AW-1:W], acc_q[W-1]};
    div_ge    = (div_shift >= {1'b0, opa_q});
    div_diff  = div_shift[W-1:0] - opa_q;
    prod_fix  = neg_q  ? (~acc_q + AW'(1)) : acc_q;
    quo_fix   = neg_q  ? (~acc_q[W-1:0] + W'(1)) : acc_q[W-1:0];
    rem_fix   = rneg_q ? (~acc_q[AW-1:W] + W'(1)) : acc_q[AW-1:W];
  end

  // Next-state and register-update logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    div_d   = div_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    busy_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              opa_d   = mag1;
              acc_d   = {W'(0), mag2};
              neg_d   = sgn_op & (In1[W-1] ^ In2[W-1]);
              rneg_d  = 1'b0;
              div_d   = 1'b0;
              dz_d    = 1'b0;
              cnt_d   = CW'(W);
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero keeps the raw dividend so it comes out as the remainder
              dz_d    = (In2 == W'(0));
              opa_d   = mag2;
              acc_d   = {W'(0), (In2 == W'(0)) ? In1 : mag1};
              neg_d   = sgn_op & (In2 != W'(0)) & (In1[W-1] ^ In2[W-1]);
              rneg_d  = sgn_op & (In2 != W'(0)) & In1[W-1];
              div_d   = 1'b1;
              cnt_d   = CW'(W);
              state_d = S_DIV;
            end
            OP_MTHI: begin
              hi_d   = In1;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = In1;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[W-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_DIV: begin
        if (div_ge) acc_d = {div_diff, acc_q[W-2:0], 1'b1};
        else        acc_d = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (div_q) begin
          hi_d = rem_fix;
          lo_d = dz_q ? {W{1'b1}} : quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Squash overrides everything, including a same-cycle request
    if (flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and architectural registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for WIDTH=32 and WIDTH=8 instances plus
// hand sequences for flush, reset, busy-time starts and back-to-back issue.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic        start32, start8;
  logic [2:0]  op;
  logic [31:0] in1, in2;
  logic        flush;
  logic        busy32, done32, busy8, done8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  int total;
  int bad;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start32), .op(op), .In1(in1), .In2(in2),
    .flush(flush), .busy(busy32), .done(done32), .Hi(hi32), .Lo(lo32)
  );

  mul_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op), .In1(in1[7:0]), .In2(in2[7:0]),
    .flush(flush), .busy(busy8), .done(done8), .Hi(hi8), .Lo(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] cur_hi(input bit w8);
    return w8 ? {24'b0, hi8} : hi32;
  endfunction
  function automatic logic [31:0] cur_lo(input bit w8);
    return w8 ? {24'b0, lo8} : lo32;
  endfunction
  function automatic logic cur_done(input bit w8);
    return w8 ? done8 : done32;
  endfunction
  function automatic logic cur_busy(input bit w8);
    return w8 ? busy8 : busy32;
  endfunction

  // Issue one op, wait for done (bounded), check latency, result, and that
  // busy held and HI/LO stayed put until the write edge.
  task automatic run(input bit w8, input logic [2:0] o, input logic [31:0] a, b,
                     input logic [31:0] eh, el, input int lat, input string nm,
                     input bit now);
    int n;
    logic steady;
    logic [31:0] h0, l0;
    if (!now) @(negedge clk);
    h0 = cur_hi(w8);
    l0 = cur_lo(w8);
    op = o; in1 = a; in2 = b;
    if (w8) start8 = 1'b1; else start32 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; start32 = 1'b0;
    n = 1;
    steady = 1'b1;
    while (!cur_done(w8) && n < 100) begin
      if (!cur_busy(w8) || cur_hi(w8) != h0 || cur_lo(w8) != l0) steady = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'(lat));
    chk({nm, "_steady"}, 32'(steady), 32'd1);
    chk({nm, "_hi"}, cur_hi(w8), eh);
    chk({nm, "_lo"}, cur_lo(w8), el);
    chk({nm, "_busy_end"}, 32'(cur_busy(w8)), 32'd0);
  endtask

  // Reference model for the WIDTH=8 instance
  task automatic model8(input logic [2:0] o, input logic [7:0] a, b,
                        output logic [7:0] eh, output logic [7:0] el);
    int sa, sb, ua, ub, p, q, r;
    logic [15:0] p16;
    sa = int'($signed(a)); sb = int'($signed(b));
    ua = int'(a); ub = int'(b);
    eh = 8'h00; el = 8'h00;
    case (o)
      3'b000: begin p = sa * sb; p16 = 16'(p); {eh, el} = p16; end
      3'b001: begin p = ua * ub; p16 = 16'(p); {eh, el} = p16; end
      3'b010: begin
        if (b == 8'h00) begin eh = a; el = 8'hFF; end
        else begin q = sa / sb; r = sa % sb; el = 8'(q); eh = 8'(r); end
      end
      default: begin
        if (b == 8'h00) begin eh = a; el = 8'hFF; end
        else begin q = ua / ub; r = ua % ub; el = 8'(q); eh = 8'(r); end
      end
    endcase
  endtask

  initial begin
    int n;
    logic saw;
    logic [7:0] ra, rb, eh8, el8;
    logic [2:0] ro;

    total = 0; bad = 0;
    reset = 1'b1; start32 = 1'b0; start8 = 1'b0; flush = 1'b0;
    op = 3'b000; in1 = '0; in2 = '0;

    vecs[0]  = '{3'b000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 34};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34};
    vecs[2]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 34};
    vecs[3]  = '{3'b000, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 34};
    vecs[4]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 34};
    vecs[5]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34};
    vecs[6]  = '{3'b011, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 34};
    vecs[7]  = '{3'b010, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 34};
    vecs[8]  = '{3'b011, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999, 34};
    vecs[9]  = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34};
    vecs[10] = '{3'b010, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 34};
    vecs[11] = '{3'b100, 32'h12345678, 32'h00000000, 32'h12345678, 32'h00000003, 1};
    vecs[12] = '{3'b101, 32'h9ABCDEF0, 32'h00000000, 32'h12345678, 32'h9ABCDEF0, 1};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy32), 32'd0);
    chk("rst_done", 32'(done32), 32'd0);
    chk("rst_hi", hi32, 32'd0);
    chk("rst_lo", lo32, 32'd0);
    chk("rst_busy8", 32'(busy8), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++)
      run(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el,
          vecs[i].lat, $sformatf("v%0d", i), 1'b0);

    // Flush in flight: no done, HI/LO keep the moved values
    @(negedge clk);
    op = 3'b000; in1 = 32'd3; in2 = 32'd4; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      if (done32) saw = 1'b1;
      @(negedge clk);
    end
    chk("flush_nodone", 32'(saw), 32'd0);
    chk("flush_busy", 32'(busy32), 32'd0);
    chk("flush_hi", hi32, 32'h12345678);
    chk("flush_lo", lo32, 32'h9ABCDEF0);

    // Flush and start together: request dropped
    op = 3'b100; in1 = 32'hDEADBEEF; start32 = 1'b1; flush = 1'b1;
    @(negedge clk);
    start32 = 1'b0; flush = 1'b0;
    chk("fs_done", 32'(done32), 32'd0);
    chk("fs_hi", hi32, 32'h12345678);

    // NOP opcode: ignored
    op = 3'b110; in1 = 32'h55; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    chk("nop_done", 32'(done32), 32'd0);
    chk("nop_busy", 32'(busy32), 32'd0);

    // Start pulse during busy is ignored; original MULT completes on time
    op = 3'b000; in1 = 32'd3; in2 = 32'd4; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0; n = 1;
    repeat (3) begin @(negedge clk); n++; end
    op = 3'b010; in1 = 32'd100; in2 = 32'd7; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0; n++;
    while (!done32 && n < 100) begin @(negedge clk); n++; end
    chk("ign_lat", 32'(n), 32'd34);
    chk("ign_hi", hi32, 32'd0);
    chk("ign_lo", lo32, 32'h0000000C);
    @(negedge clk);
    chk("done_pulse", 32'(done32), 32'd0);

    // Back-to-back: new request issued in the done cycle
    run(1'b0, 3'b001, 32'd3, 32'd4, 32'd0, 32'h0000000C, 34, "b2b_a", 1'b0);
    run(1'b0, 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 34, "b2b_b", 1'b1);

    // Reset mid-DIV clears everything immediately
    @(negedge clk);
    op = 3'b010; in1 = 32'd100; in2 = 32'd7; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy32), 32'd0);
    chk("mrst_done", 32'(done32), 32'd0);
    chk("mrst_hi", hi32, 32'd0);
    chk("mrst_lo", lo32, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run(1'b0, 3'b001, 32'd3, 32'd4, 32'd0, 32'h0000000C, 34, "post_rst", 1'b0);

    // WIDTH=8 instance
    run(1'b1, 3'b010, 32'h80, 32'h03, 32'hFE, 32'hD6, 10, "w8_div", 1'b0);
    for (int k = 0; k < 16; k++) begin
      ro = 3'($urandom_range(0, 3));
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      model8(ro, ra, rb, eh8, el8);
      run(1'b1, ro, {24'b0, ra}, {24'b0, rb}, {24'b0, eh8}, {24'b0, el8}, 10,
          $sformatf("w8_r%0d", k), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
